// File: rtl/flash_hps_bridge.sv
// flash_hps_bridge: HPS lightweight-bus bridge to the FLASH scheduler core.
// Define FLASH_TICK_STATS_EN to build the tick_count/missed_ticks status counters.
module flash_hps_bridge #(
  parameter int PID_W      = 16,
  parameter int PRI_W      = 8,
  parameter int STATE_W    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hps_req,
  input  logic               hps_read,
  input  logic [1:0]         hps_address,
  input  logic [63:0]        hps_change_data,
  output logic [63:0]        hps_readdata,
  output logic               hps_tick_irq,
  output logic               sched_req,
  input  logic               sched_grant,
  input  logic [PID_W-1:0]   next_process,
  input  logic               tick_req,
  output logic               tick_grant,
  output logic               change_req,
  input  logic               change_grant,
  output logic [7:0]         change_type,
  output logic [PID_W-1:0]   change_pid,
  output logic [PRI_W-1:0]   change_pri,
  output logic [STATE_W-1:0] change_state
);

  localparam int CHG_W = 8 + PID_W + PRI_W + STATE_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_LOW} sched_state_t;
  typedef enum logic [1:0] {C_IDLE, C_REQ, C_WAIT_LOW} chg_state_t;
  typedef enum logic       {T_IDLE, T_ACK}             tick_state_t;

  sched_state_t s_state;
  chg_state_t   c_state;
  tick_state_t  t_state;

  logic [PID_W-1:0] result;
  logic             result_valid;
  logic             sched_drop;
  logic             change_ovf;
  logic             irq_pend;

  logic [CHG_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [CHG_W-1:0] head;
  logic             full, push, pop;

  logic wr_sched, wr_chg, rd_result, rd_status, tick_acc;
  logic [15:0] tick_stats;
  logic [63:0] status;

  assign wr_sched  = hps_req  && (hps_address == 2'd0);
  assign wr_chg    = hps_req  && (hps_address == 2'd1);
  assign rd_result = hps_read && (hps_address == 2'd0);
  assign rd_status = hps_read && (hps_address == 2'd1);

  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = (c_state == C_REQ) && change_grant;
  // A write into a full FIFO still lands when the head leaves on the same edge.
  assign push     = wr_chg && (!full || pop);
  assign head     = mem[rd_ptr];
  assign tick_acc = (t_state == T_IDLE) && tick_req;

  assign hps_tick_irq = irq_pend;

  generate
    if (CHG_W < 64) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^hps_change_data[63:CHG_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s_state      <= S_IDLE;
      sched_req    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      sched_drop   <= 1'b0;
    end else begin
      if (rd_result) result_valid <= 1'b0;
      if (rd_status) sched_drop   <= 1'b0;
      case (s_state)
        S_IDLE: if (wr_sched) begin
          sched_req <= 1'b1;
          s_state   <= S_REQ;
        end
        S_REQ: if (sched_grant) begin
          result       <= next_process;
          result_valid <= 1'b1;
          sched_req    <= 1'b0;
          s_state      <= S_WAIT_LOW;
        end
        S_WAIT_LOW: if (!sched_grant) s_state <= S_IDLE;
        default: s_state <= S_IDLE;
      endcase
      if (wr_sched && (s_state != S_IDLE)) sched_drop <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= hps_change_data[CHG_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_state      <= C_IDLE;
      change_req   <= 1'b0;
      change_type  <= '0;
      change_pid   <= '0;
      change_pri   <= '0;
      change_state <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      change_ovf   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (rd_status) change_ovf <= 1'b0;
      if (wr_chg && full && !pop) change_ovf <= 1'b1;
      case (c_state)
        C_IDLE: if (count != '0) begin
          change_req   <= 1'b1;
          change_type  <= head[7:0];
          change_pid   <= head[8 +: PID_W];
          change_pri   <= head[8 + PID_W +: PRI_W];
          change_state <= head[8 + PID_W + PRI_W +: STATE_W];
          c_state      <= C_REQ;
        end
        C_REQ: if (change_grant) begin
          change_req <= 1'b0;
          c_state    <= C_WAIT_LOW;
        end
        C_WAIT_LOW: if (!change_grant) c_state <= C_IDLE;
        default: c_state <= C_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_state    <= T_IDLE;
      tick_grant <= 1'b0;
      irq_pend   <= 1'b0;
    end else begin
      if (rd_result) irq_pend <= 1'b0;
      case (t_state)
        T_IDLE: if (tick_req) begin
          tick_grant <= 1'b1;
          irq_pend   <= 1'b1;
          t_state    <= T_ACK;
        end
        T_ACK: if (!tick_req) begin
          tick_grant <= 1'b0;
          t_state    <= T_IDLE;
        end
        default: t_state <= T_IDLE;
      endcase
    end
  end

`ifdef FLASH_TICK_STATS_EN
  logic [7:0] tick_count, missed_ticks;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_count   <= '0;
      missed_ticks <= '0;
    end else begin
      if (tick_acc) tick_count <= tick_count + 8'd1;
      // A miss counted in the same cycle as a status read survives the clear.
      if (tick_acc && irq_pend)
        missed_ticks <= rd_status ? 8'd1 :
                        (missed_ticks == 8'hFF) ? 8'hFF : missed_ticks + 8'd1;
      else if (rd_status)
        missed_ticks <= '0;
    end
  end

  assign tick_stats = {missed_ticks, tick_count};
`else
  logic unused_tick_acc;
  assign unused_tick_acc = tick_acc;
  assign tick_stats      = '0;
`endif

  always_comb begin
    status        = '0;
    status[7:0]   = 8'(count);
    status[8]     = change_ovf;
    status[9]     = sched_drop;
    status[10]    = full;
    status[11]    = (s_state != S_IDLE);
    status[31:16] = tick_stats;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hps_readdata <= '0;
    end else if (hps_read) begin
      case (hps_address)
        2'd0:    hps_readdata <= {result_valid, {(63 - PID_W){1'b0}}, result};
        2'd1:    hps_readdata <= status;
        default: hps_readdata <= '0;
      endcase
    end
  end

endmodule
